lfsr_draw_engine: RTL and testbench



---
 rtl/lfsr_draw_engine.sv | 139 +++++++++++++
 tb/tb_lfsr_draw_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_draw_engine.sv
// lfsr_draw_engine: XNOR-feedback Fibonacci LFSR with a request/valid draw
// handshake, seed loading, optional free-running and STEPS shifts per draw.
// The draw value q feeds the game FSM as code / direction / rotation fields.
//
// Optional build macro: LFSR_LOCKUP_GUARD_EN
//   defined   -> a shift that starts from the all-ones state loads SEED
//                (or 0 if SEED is all-ones) and sets the sticky lockup flag.
//   undefined -> no detection; lockup is tied low and all-ones persists.
//
// Handshake: draw_req is sampled only while busy is low (IDLE). An accepted
// request produces exactly one draw_valid pulse, in the cycle in which q
// first shows the new draw, unless seed_load or reset aborts it first.
// Requests seen while busy is high are dropped, never queued.
module lfsr_draw_engine #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h8E,
  parameter int               STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             free_run,
  input  logic             draw_req,
  output logic             busy,
  output logic             draw_valid,
  output logic [WIDTH-1:0] q,
  output logic [3:0]       code,
  output logic [1:0]       direction,
  output logic [1:0]       rotation_duration,
  output logic [CNT_W-1:0] draw_count,
  output logic             lockup
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [1:0]       fsm;
  logic [7:0]       step_cnt;
  logic             shift_en;

  // Flags every edge on which the LFSR actually shifts (free-run or draw).
  always_comb begin
    shift_en = 1'b0;
    if (!seed_load) begin
      case (fsm)
        ST_IDLE:  shift_en = free_run && !draw_req;
        ST_SHIFT: shift_en = 1'b1;
        default:  shift_en = 1'b0;
      endcase
    end
  end

`ifdef LFSR_LOCKUP_GUARD_EN
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] GUARD_VAL = (SEED == ALL_ONES) ? '0 : SEED;

  // Next LFSR value; escapes the all-ones lock-up state instead of shifting.
  always_comb begin
    lfsr_next = {lfsr[WIDTH-2:0], ~^(lfsr & TAPS)};
    if (&lfsr) lfsr_next = GUARD_VAL;
  end

  // Sticky flag: set by any shift that started from all-ones, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lockup <= 1'b0;
    end else if (shift_en && (&lfsr)) begin
      lockup <= 1'b1;
    end
  end
`else
  // Next LFSR value: plain XNOR Fibonacci shift.
  always_comb begin
    lfsr_next = {lfsr[WIDTH-2:0], ~^(lfsr & TAPS)};
  end

  assign lockup = 1'b0;
`endif

  // Draw FSM, LFSR state, step counter, output register and draw counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr       <= SEED;
      fsm        <= ST_IDLE;
      step_cnt   <= 8'd0;
      q          <= '0;
      draw_count <= '0;
    end else if (seed_load) begin
      // Seed load aborts any draw: q and draw_count are left untouched.
      lfsr     <= seed;
      fsm      <= ST_IDLE;
      step_cnt <= 8'd0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (draw_req) begin
            fsm      <= ST_SHIFT;
            step_cnt <= 8'd0;
          end else if (free_run) begin
            lfsr <= lfsr_next;
          end
        end
        ST_SHIFT: begin
          lfsr <= lfsr_next;
          if (step_cnt == LAST_STEP) begin
            q        <= lfsr_next;
            fsm      <= ST_DONE;
            step_cnt <= 8'd0;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          fsm        <= ST_IDLE;
          draw_count <= draw_count + 1'b1;
        end
        default: begin
          fsm      <= ST_IDLE;
          step_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign busy              = (fsm != ST_IDLE);
  assign draw_valid        = (fsm == ST_DONE);
  assign code              = q[3:0];
  assign direction         = {q[0], q[2]};
  assign rotation_duration = {q[1], q[3]};

endmodule

// File: tb/tb_lfsr_draw_engine.sv
// Testbench for lfsr_draw_engine: three instances (STEPS = 1, 3, 4) share the
// clock and reset; each has its own control inputs. A transaction-level model
// tracks the LFSR value per instance, and a scoreboard queue holds the
// expected q of every accepted draw, tagged with the instance number.
module tb_lfsr_draw_engine;

  localparam logic [7:0] TAPS = 8'h8E;
  localparam logic [7:0] SEED = 8'h00;

  logic        clk;
  logic        reset;
  logic [2:0]  seed_load;
  logic [2:0]  free_run;
  logic [2:0]  draw_req;
  logic [7:0]  seed;
  logic [2:0]  busy_o;
  logic [2:0]  valid_o;
  logic [2:0]  lock_o;
  logic [7:0]  q_o    [3];
  logic [3:0]  code_o [3];
  logic [1:0]  dir_o  [3];
  logic [1:0]  rot_o  [3];
  logic [15:0] cnt_o  [3];

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {instance[1:0], expected q[7:0]} per accepted draw.
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  // Reference model state per instance.
  logic [7:0] m_state [3];
  logic [7:0] m_q     [3];
  logic [2:0] m_lock;
  int         m_cnt   [3];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lfsr_draw_engine #(
      .WIDTH(8), .TAPS(TAPS), .STEPS((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .SEED(SEED), .CNT_W(16)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .seed_load        (seed_load[g]),
      .seed             (seed),
      .free_run         (free_run[g]),
      .draw_req         (draw_req[g]),
      .busy             (busy_o[g]),
      .draw_valid       (valid_o[g]),
      .q                (q_o[g]),
      .code             (code_o[g]),
      .direction        (dir_o[g]),
      .rotation_duration(rot_o[g]),
      .draw_count       (cnt_o[g]),
      .lockup           (lock_o[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int steps_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  // Model: advance instance i by n LFSR steps. Feedback bit is 1 when the
  // tapped bits contain an even number of ones.
  task automatic advance(input int i, input int n);
    logic [7:0] s;
    s = m_state[i];
    for (int k = 0; k < n; k++) begin
`ifdef LFSR_LOCKUP_GUARD_EN
      if (s == 8'hFF) begin
        s = (SEED == 8'hFF) ? 8'h00 : SEED;
        m_lock[i] = 1'b1;
        continue;
      end
`endif
      s = 8'((s * 2) + ((($countones(s & TAPS) % 2) == 0) ? 1 : 0));
    end
    m_state[i] = s;
  endtask

  // Scoreboard monitor: every draw_valid pulse must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_o[i]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(i), 32'hFF);
          end else begin
            mon_e = exp_q.pop_front();
            check("valid_instance", 32'(i), 32'(mon_e[9:8]));
            check("draw_q", 32'(q_o[i]), 32'(mon_e[7:0]));
            check("code", 32'(code_o[i]), 32'(mon_e[3:0]));
            check("direction", 32'(dir_o[i]), 32'({mon_e[0], mon_e[2]}));
            check("rotation", 32'(rot_o[i]), 32'({mon_e[1], mon_e[3]}));
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    reset = 1'b0; seed_load = '0; free_run = '0; draw_req = '0; seed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    m_lock = '0;
    for (int i = 0; i < 3; i++) begin
      m_state[i] = SEED; m_q[i] = 8'h00; m_cnt[i] = 0;
      check("reset_q", 32'(q_o[i]), 32'h0);
      check("reset_valid", 32'(valid_o[i]), 32'h0);
      check("reset_busy", 32'(busy_o[i]), 32'h0);
      check("reset_count", 32'(cnt_o[i]), 32'h0);
      check("reset_lockup", 32'(lock_o[i]), 32'h0);
    end
  endtask

  task automatic do_draw(input int i);
    int cyc;
    int st;
    st = steps_of(i);
    advance(i, st);
    m_q[i] = m_state[i];
    exp_q.push_back({2'(i), m_state[i]});
    draw_req[i] = 1'b1;
    @(negedge clk);
    draw_req[i] = 1'b0;
    cyc = 1;
    while (!valid_o[i] && cyc < 300) begin
      check("busy_in_shift", 32'(busy_o[i]), 32'h1);
      @(negedge clk);
      cyc++;
    end
    check("draw_latency", 32'(cyc), 32'(st + 1));
    check("busy_in_done", 32'(busy_o[i]), 32'h1);
    @(negedge clk);
    m_cnt[i]++;
    check("busy_after", 32'(busy_o[i]), 32'h0);
    check("valid_one_cycle", 32'(valid_o[i]), 32'h0);
    check("draw_count", 32'(cnt_o[i]), 32'(m_cnt[i] % 65536));
  endtask

  task automatic do_free_run(input int i, input int n);
    free_run[i] = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("q_hold_free_run", 32'(q_o[i]), 32'(m_q[i]));
    end
    free_run[i] = 1'b0;
    advance(i, n);
  endtask

  task automatic do_seed(input int i, input logic [7:0] v);
    seed = v;
    seed_load[i] = 1'b1;
    @(negedge clk);
    seed_load[i] = 1'b0;
    m_state[i] = v;
    check("q_hold_seed", 32'(q_o[i]), 32'(m_q[i]));
  endtask

  initial begin
    int accepted;
    int guard_cnt;

    // Four STEPS=1 draws from reset.
    do_reset();
    do_draw(0); check("tp1_q0", 32'(q_o[0]), 32'h01);
    do_draw(0); check("tp1_q1", 32'(q_o[0]), 32'h03);
    do_draw(0); check("tp1_q2", 32'(q_o[0]), 32'h06);
    do_draw(0); check("tp1_q3", 32'(q_o[0]), 32'h0D);
    check("tp1_code", 32'(code_o[0]), 32'hD);
    check("tp1_dir", 32'(dir_o[0]), 32'h3);
    check("tp1_rot", 32'(rot_o[0]), 32'h1);
    check("tp1_count", 32'(cnt_o[0]), 32'd4);

    // STEPS=3 draw from reset.
    do_draw(1); check("tp2_q", 32'(q_o[1]), 32'h06);

    // Free-run two cycles then a STEPS=1 draw.
    do_reset();
    do_free_run(0, 2);
    do_draw(0); check("tp3_q", 32'(q_o[0]), 32'h06);

    // Seed load in the second SHIFT cycle of a STEPS=4 draw aborts it.
    do_draw(2);
    seed = 8'h55;
    draw_req[2] = 1'b1;
    @(negedge clk);
    draw_req[2] = 1'b0;
    @(negedge clk);
    seed_load[2] = 1'b1;
    @(negedge clk);
    seed_load[2] = 1'b0;
    m_state[2] = 8'h55;
    check("abort_busy", 32'(busy_o[2]), 32'h0);
    for (int k = 0; k < 6; k++) begin
      check("abort_no_valid", 32'(valid_o[2]), 32'h0);
      @(negedge clk);
    end
    check("abort_count", 32'(cnt_o[2]), 32'(m_cnt[2]));
    check("abort_q", 32'(q_o[2]), 32'(m_q[2]));
    do_draw(2);

    // Continuous request for 20 cycles, STEPS=1: one draw per 3 cycles.
    do_reset();
    accepted = (20 + 2) / 3;
    for (int k = 0; k < accepted; k++) begin
      advance(0, 1);
      exp_q.push_back({2'd0, m_state[0]});
    end
    m_q[0] = m_state[0];
    draw_req[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("b2b_count_window", 32'(cnt_o[0]), 32'(20 / 3));
    draw_req[0] = 1'b0;
    guard_cnt = 0;
    while (busy_o[0] && guard_cnt < 50) begin
      @(negedge clk);
      guard_cnt++;
    end
    check("b2b_drain", 32'(busy_o[0]), 32'h0);
    m_cnt[0] = accepted;
    check("b2b_count_final", 32'(cnt_o[0]), 32'(accepted));
    check("b2b_queue_empty", 32'(exp_q.size()), 32'h0);

    // All-ones seed then a STEPS=1 draw.
    do_reset();
    do_seed(0, 8'hFF);
    do_draw(0);
`ifdef LFSR_LOCKUP_GUARD_EN
    check("lock_q", 32'(q_o[0]), 32'h00);
    check("lock_flag", 32'(lock_o[0]), 32'h1);
`else
    check("lock_q", 32'(q_o[0]), 32'hFF);
    check("lock_flag", 32'(lock_o[0]), 32'h0);
`endif
    check("lock_model", 32'(lock_o[0]), 32'(m_lock[0]));

    // Randomized operation mix across the three instances.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int i;
      int op;
      i  = $urandom_range(0, 2);
      op = $urandom_range(0, 4);
      case (op)
        0, 1, 2: do_draw(i);
        3:       do_free_run(i, $urandom_range(1, 6));
        default: do_seed(i, 8'($urandom_range(0, 255)));
      endcase
    end
    for (int i = 0; i < 3; i++) begin
      check("rand_lockup", 32'(lock_o[i]), 32'(m_lock[i]));
      check("rand_count", 32'(cnt_o[i]), 32'(m_cnt[i]));
    end
    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
